// File: rtl/cdb_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | cdb_arbiter_pkg: shared widths, encodings and types for the CDB arbiter. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package cdb_arbiter_pkg;

  localparam int ROB_ID_W       = 4;
  localparam int DATA_W         = 32;
  localparam int CDB_FIFO_DEPTH = 4;
  localparam int PTR_W          = 2;
  localparam int CNT_W          = 3;
  localparam int STAT_W         = 32;

  localparam logic [ROB_ID_W-1:0] ZERO_ROB = '0;
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(CDB_FIFO_DEPTH);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   result;
  } cdb_entry_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | cdb_arbiter_if: requester, control and broadcast signals of the arbiter. |
// | Optional counters appear when CDB_ARB_STATS_EN is defined.  Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic                rdy;
  logic                flush_in;
  logic                alu_valid_in;
  logic [ROB_ID_W-1:0] alu_rob_id_in;
  logic [DATA_W-1:0]   alu_result_in;
  logic                lsb_valid_in;
  logic [ROB_ID_W-1:0] lsb_rob_id_in;
  logic [DATA_W-1:0]   lsb_result_in;
  logic                alu_ready_out;
  logic                lsb_ready_out;
  logic                cdb_valid_out;
  logic [ROB_ID_W-1:0] cdb_rob_id_out;
  logic [DATA_W-1:0]   cdb_result_out;
  logic                cdb_src_out;
`ifdef CDB_ARB_STATS_EN
  logic [STAT_W-1:0]   conflict_cnt_out;
  logic [STAT_W-1:0]   full_cnt_out;
`endif

  modport slave (
    input  rdy, flush_in,
    input  alu_valid_in, alu_rob_id_in, alu_result_in,
    input  lsb_valid_in, lsb_rob_id_in, lsb_result_in,
    output alu_ready_out, lsb_ready_out,
    output cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out
`ifdef CDB_ARB_STATS_EN
    , output conflict_cnt_out, full_cnt_out
`endif
  );

  modport master (
    output rdy, flush_in,
    output alu_valid_in, alu_rob_id_in, alu_result_in,
    output lsb_valid_in, lsb_rob_id_in, lsb_result_in,
    input  alu_ready_out, lsb_ready_out,
    input  cdb_valid_out, cdb_rob_id_out, cdb_result_out, cdb_src_out
`ifdef CDB_ARB_STATS_EN
    , input conflict_cnt_out, full_cnt_out
`endif
  );

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter_fifo.sv
// +--------------------------------------------------------------------------+
// | cdb_fifo: 4-entry result queue with clear; no arbitration inside.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module cdb_fifo
  import cdb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  cdb_entry_t       push_data,
  input  logic             pop,
  output cdb_entry_t       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  cdb_entry_t       mem_q [CDB_FIFO_DEPTH];
  cdb_entry_t       mem_d [CDB_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop on an empty queue is legal only alongside a push: the entry is
  // written and consumed in the same cycle, leaving the count at zero.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CDB_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// +--------------------------------------------------------------------------+
// | cdb_arbiter: round-robin CDB arbiter over ALU and LSB result queues.     |
// | Optional CDB_ARB_STATS_EN adds conflict / full cycle counters. Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);

  cdb_entry_t          alu_req, lsb_req, alu_head, lsb_head, alu_cand, lsb_cand;
  logic [CNT_W-1:0]    alu_count, lsb_count;
  logic                alu_full, lsb_full, alu_empty, lsb_empty;
  logic                alu_push, lsb_push, alu_avail, lsb_avail;
  logic                grant_alu, grant_lsb;

  cdb_src_e            last_grant_q, last_grant_d;
  logic                cdb_valid_q, cdb_valid_d;
  logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [DATA_W-1:0]   cdb_result_q, cdb_result_d;
  cdb_src_e            cdb_src_q, cdb_src_d;

  assign alu_req = {bus.alu_rob_id_in, bus.alu_result_in};
  assign lsb_req = {bus.lsb_rob_id_in, bus.lsb_result_in};

  cdb_fifo u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.flush_in),
    .push      (alu_push),
    .push_data (alu_req),
    .pop       (grant_alu),
    .head      (alu_head),
    .count     (alu_count),
    .full      (alu_full),
    .empty     (alu_empty)
  );

  cdb_fifo u_lsb_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.flush_in),
    .push      (lsb_push),
    .push_data (lsb_req),
    .pop       (grant_lsb),
    .head      (lsb_head),
    .count     (lsb_count),
    .full      (lsb_full),
    .empty     (lsb_empty)
  );

  assign bus.alu_ready_out  = !alu_full;
  assign bus.lsb_ready_out  = !lsb_full;
  assign bus.cdb_valid_out  = cdb_valid_q;
  assign bus.cdb_rob_id_out = cdb_rob_id_q;
  assign bus.cdb_result_out = cdb_result_q;
  assign bus.cdb_src_out    = cdb_src_q;

  always_comb begin
    alu_push = bus.alu_valid_in && !alu_full && bus.rdy && !bus.flush_in &&
               (bus.alu_rob_id_in != ZERO_ROB);
    lsb_push = bus.lsb_valid_in && !lsb_full && bus.rdy && !bus.flush_in &&
               (bus.lsb_rob_id_in != ZERO_ROB);

    // An arriving request into an empty queue competes immediately.
    alu_avail = (alu_count != '0) || alu_push;
    lsb_avail = (lsb_count != '0) || lsb_push;
    alu_cand  = alu_empty ? alu_req : alu_head;
    lsb_cand  = lsb_empty ? lsb_req : lsb_head;

    grant_alu = 1'b0;
    grant_lsb = 1'b0;
    if (bus.rdy && !bus.flush_in) begin
      if (alu_avail && lsb_avail) begin
        grant_alu = (last_grant_q == SRC_LSB);
        grant_lsb = (last_grant_q == SRC_ALU);
      end else begin
        grant_alu = alu_avail;
        grant_lsb = lsb_avail;
      end
    end

    last_grant_d = last_grant_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_result_d = cdb_result_q;
    cdb_src_d    = cdb_src_q;
    // A flush is a commit-time redirect and must not be lost to a stall,
    // so it clears the bus even when rdy is low.
    if (bus.flush_in) begin
      cdb_valid_d = 1'b0;
    end else if (bus.rdy) begin
      cdb_valid_d = grant_alu || grant_lsb;
      if (grant_alu) begin
        cdb_rob_id_d = alu_cand.rob_id;
        cdb_result_d = alu_cand.result;
        cdb_src_d    = SRC_ALU;
        last_grant_d = SRC_ALU;
      end else if (grant_lsb) begin
        cdb_rob_id_d = lsb_cand.rob_id;
        cdb_result_d = lsb_cand.result;
        cdb_src_d    = SRC_LSB;
        last_grant_d = SRC_LSB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SRC_LSB;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_result_q <= '0;
      cdb_src_q    <= SRC_ALU;
    end else begin
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_result_q <= cdb_result_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [STAT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic [STAT_W-1:0] full_cnt_q, full_cnt_d;

  assign bus.conflict_cnt_out = conflict_cnt_q;
  assign bus.full_cnt_out     = full_cnt_q;

  // Counters sample the registered queue state, independent of flush.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    full_cnt_d     = full_cnt_q;
    if (bus.rdy) begin
      if (!alu_empty && !lsb_empty) begin
        conflict_cnt_d = sat_inc(conflict_cnt_q);
      end
      if (alu_full || lsb_full) begin
        full_cnt_d = sat_inc(full_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      full_cnt_q     <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      full_cnt_q     <= full_cnt_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_cdb_arbiter: vector table, directed sequences and randomized traffic  |
// | checked against a queue-based reference model. Rev 1.0                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if bus ();

  cdb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] d;
  } ent_t;

  typedef struct packed {
    logic        rdy;
    logic        av;
    logic [3:0]  aid;
    logic [31:0] ad;
    logic        lv;
    logic [3:0]  lid;
    logic [31:0] ld;
    logic        ev;
    logic [3:0]  eid;
    logic [31:0] ed;
    logic        es;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per source and the identity of the last winner.
  ent_t        qa[$];
  ent_t        ql[$];
  logic        m_valid;
  logic [3:0]  m_id;
  logic [31:0] m_data;
  logic        m_src;
  logic        m_last;
  logic [31:0] m_conf;
  logic [31:0] m_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic av, input logic [3:0] aid,
                       input logic [31:0] ad, input logic lv, input logic [3:0] lid,
                       input logic [31:0] ld);
    bus.rdy           = r;
    bus.flush_in      = f;
    bus.alu_valid_in  = av;
    bus.alu_rob_id_in = aid;
    bus.alu_result_in = ad;
    bus.lsb_valid_in  = lv;
    bus.lsb_rob_id_in = lid;
    bus.lsb_result_in = ld;
  endtask

  task automatic model_step();
    ent_t e;
    logic ga, gl;
    if (rst) begin
      qa.delete();
      ql.delete();
      m_valid = 1'b0; m_id = '0; m_data = '0; m_src = 1'b0; m_last = 1'b1;
      m_conf = '0; m_full = '0;
      return;
    end
    if (bus.rdy) begin
      if (qa.size() > 0 && ql.size() > 0 && m_conf != 32'hFFFF_FFFF) m_conf++;
      if ((qa.size() == 4 || ql.size() == 4) && m_full != 32'hFFFF_FFFF) m_full++;
    end
    if (bus.flush_in) begin
      qa.delete();
      ql.delete();
      m_valid = 1'b0;
      return;
    end
    if (!bus.rdy) return;
    if (bus.alu_valid_in && qa.size() < 4 && bus.alu_rob_id_in != 4'd0) begin
      e.id = bus.alu_rob_id_in; e.d = bus.alu_result_in; qa.push_back(e);
    end
    if (bus.lsb_valid_in && ql.size() < 4 && bus.lsb_rob_id_in != 4'd0) begin
      e.id = bus.lsb_rob_id_in; e.d = bus.lsb_result_in; ql.push_back(e);
    end
    ga = (qa.size() > 0) && (ql.size() == 0 || m_last == 1'b1);
    gl = (ql.size() > 0) && !ga;
    m_valid = ga || gl;
    if (ga) begin
      e = qa.pop_front(); m_src = 1'b0;
    end else if (gl) begin
      e = ql.pop_front(); m_src = 1'b1;
    end
    if (m_valid) begin
      m_id = e.id; m_data = e.d; m_last = m_src;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(bus.cdb_valid_out), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".id"},   32'(bus.cdb_rob_id_out), 32'(m_id));
      chk({tag, ".data"}, bus.cdb_result_out, m_data);
      chk({tag, ".src"},  32'(bus.cdb_src_out), 32'(m_src));
    end
    chk({tag, ".alu_rdy"}, 32'(bus.alu_ready_out), 32'(qa.size() < 4));
    chk({tag, ".lsb_rdy"}, 32'(bus.lsb_ready_out), 32'(ql.size() < 4));
`ifdef CDB_ARB_STATS_EN
    chk({tag, ".conf_cnt"}, bus.conflict_cnt_out, m_conf);
    chk({tag, ".full_cnt"}, bus.full_cnt_out, m_full);
`endif
  endtask

  task automatic step(input string tag);
    model_step();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    step("reset");
    rst = 1'b0;
  endtask

  vec_t tbl[13];
  logic [3:0] a_next, a_out, l_next;
  logic       saw_low, acc;

  initial begin
    // conflict, drain, single request, ZERO_ROB drop, freeze with valid held
    tbl[0]  = '{1, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2, 1, 4'd1, 32'hA1, 0};
    tbl[1]  = '{1, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 4'd2, 32'hB2, 1};
    tbl[2]  = '{1, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0};
    tbl[3]  = '{1, 1, 4'd3, 32'h11, 0, 4'd0, 32'h0,  1, 4'd3, 32'h11, 0};
    tbl[4]  = '{1, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0};
    tbl[5]  = '{1, 1, 4'd0, 32'h55, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0};
    tbl[6]  = '{1, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0};
    tbl[7]  = '{1, 0, 4'd0, 32'h0,  1, 4'd5, 32'h77, 1, 4'd5, 32'h77, 1};
    tbl[8]  = '{0, 1, 4'd6, 32'h66, 0, 4'd0, 32'h0,  1, 4'd5, 32'h77, 1};
    tbl[9]  = '{0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 4'd5, 32'h77, 1};
    tbl[10] = '{0, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  1, 4'd5, 32'h77, 1};
    tbl[11] = '{1, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0};
    tbl[12] = '{1, 0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0, 4'd0, 32'h0,  0};

    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    model_step();
    @(negedge clk);
    rst = 1'b0;
    chk("rst.valid",   32'(bus.cdb_valid_out), 32'd0);
    chk("rst.id",      32'(bus.cdb_rob_id_out), 32'd0);
    chk("rst.data",    bus.cdb_result_out, 32'd0);
    chk("rst.src",     32'(bus.cdb_src_out), 32'd0);
    chk("rst.alu_rdy", 32'(bus.alu_ready_out), 32'd1);
    chk("rst.lsb_rdy", 32'(bus.lsb_ready_out), 32'd1);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rdy, 1'b0, tbl[i].av, tbl[i].aid, tbl[i].ad,
            tbl[i].lv, tbl[i].lid, tbl[i].ld);
      model_step();
      @(negedge clk);
      chk($sformatf("vec%0d.valid", i), 32'(bus.cdb_valid_out), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d.id", i),   32'(bus.cdb_rob_id_out), 32'(tbl[i].eid));
        chk($sformatf("vec%0d.data", i), bus.cdb_result_out, tbl[i].ed);
        chk($sformatf("vec%0d.src", i),  32'(bus.cdb_src_out), 32'(tbl[i].es));
      end
      chk($sformatf("vec%0d.alu_rdy", i), 32'(bus.alu_ready_out), 32'd1);
    end

    // Backpressure: both sources push every cycle, so each queue fills.
    do_reset();
    a_next = 4'd1; a_out = 4'd1; l_next = 4'd1; saw_low = 1'b0;
    for (int c = 0; c < 24; c++) begin
      acc = (c < 12) && (qa.size() < 4);
      drive(1'b1, 1'b0, c < 12, a_next, {28'h0A1A, a_next}, c < 12, l_next, {28'h0B1B, l_next});
      step("bp");
      if (acc) a_next++;
      l_next = (l_next == 4'd15) ? 4'd1 : l_next + 4'd1;
      if (!bus.alu_ready_out) saw_low = 1'b1;
      if (bus.cdb_valid_out && bus.cdb_src_out == 1'b0) begin
        chk("bp.order", 32'(bus.cdb_rob_id_out), 32'(a_out));
        a_out++;
      end
    end
    chk("bp.ready_low_seen", 32'(saw_low), 32'd1);
    chk("bp.none_lost", 32'(a_out), 32'(a_next));

    // Flush with queued entries.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b1, 4'(c + 1), 32'(c + 32'h100), 1'b1, 4'(c + 4), 32'(c + 32'h200));
      step("fl.fill");
    end
    drive(1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    step("fl.pulse");
    chk("fl.valid", 32'(bus.cdb_valid_out), 32'd0);
    chk("fl.alu_rdy", 32'(bus.alu_ready_out), 32'd1);
    chk("fl.lsb_rdy", 32'(bus.lsb_ready_out), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    for (int c = 0; c < 3; c++) step("fl.idle");
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h99);
    step("fl.new");
    chk("fl.new_valid", 32'(bus.cdb_valid_out), 32'd1);

    // Mid-operation reset discards everything.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 1'b1, 4'(c + 7), 32'hC0 + 32'(c), 1'b1, 4'(c + 10), 32'hD0 + 32'(c));
      step("mr.fill");
    end
    rst = 1'b1;
    step("mr.rst");
    chk("mr.valid", 32'(bus.cdb_valid_out), 32'd0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    step("mr.idle");
    chk("mr.idle_valid", 32'(bus.cdb_valid_out), 32'd0);

`ifdef CDB_ARB_STATS_EN
    // Two cycles with both queues non-empty, then a flush ends the conflict.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h2); step("st");
    drive(1'b1, 1'b0, 1'b1, 4'd3, 32'h3, 1'b1, 4'd4, 32'h4); step("st");
    drive(1'b1, 1'b0, 1'b1, 4'd5, 32'h5, 1'b1, 4'd6, 32'h6); step("st");
    drive(1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0); step("st");
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0); step("st");
    chk("st.conflict_two", bus.conflict_cnt_out, 32'd2);
    do_reset();
    chk("st.conflict_rst", bus.conflict_cnt_out, 32'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 99) < 60, 4'($urandom_range(0, 15)), $urandom);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
